add_share_arbiter: RTL and testbench
====================================

// Module: add_share_arbiter
// PURPOSE
//  Shares one 32-bit carry-lookahead adder (module Add) between NREQ requesters.
//  Grants requesters round-robin over per-port valid/ready handshakes.
//  Registers each sum together with the requester ID and presents it on a single
//  response channel that supports backpressure.
//  Sits between the ALU/address-generation clients and the shared Add instance.
// PARAMETERS
//  NREQ   4  number of requester ports (2..16)
//  ID_W   $clog2(NREQ)  width of the response ID; derived, never overridden
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   NREQ       request pending, one bit per port
//  req_ready  out  NREQ       port i's request is accepted this cycle (one-hot or zero)
//  req_a      in   NREQ*32    operand A; port i uses bits [32*i+31:32*i]
//  req_b      in   NREQ*32    operand B; same packing as req_a
//  rsp_valid  out  1          response register holds a result
//  rsp_ready  in   1          consumer accepts the response
//  rsp_sum    out  32         (a+b) mod 2^32
//  rsp_id     out  ID_W       index of the requester that produced rsp_sum
//  grant_cnt  out  16         total accepted requests, wraps at 2^16
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_sum=0, rsp_id=0, grant_cnt=0, rr_ptr=0.
//   req_ready is 0 while rst_n is low.
//  States:
//   EMPTY: rsp_valid=0.
//   FULL:  rsp_valid=1.
//  can_accept = (state==EMPTY) | rsp_ready.
//  Grant: when can_accept and req_valid!=0, exactly one port g is granted.
//   g is the first set bit of req_valid, scanning upward from rr_ptr and
//   wrapping at NREQ-1 -> 0.
//   req_ready[g]=1; all other bits 0. req_ready is combinational from
//   req_valid/state/rsp_ready; a requester must not make valid depend on ready.
//  Datapath: Add sees the muxed operands req_a[g] and req_b[g] combinationally.
//   On the grant edge: rsp_sum <= Add.sum, rsp_id <= g, rr_ptr <= (g+1) mod NREQ,
//   grant_cnt++. Latency is 1 cycle from acceptance to rsp_valid.
//  Transitions:
//   EMPTY + grant              -> FULL
//   FULL + rsp_ready + grant   -> FULL (new result loaded; throughput 1/cycle)
//   FULL + rsp_ready + no req  -> EMPTY
//   FULL + !rsp_ready          -> FULL; rsp_sum/rsp_id held stable; req_ready=0
//  No grant -> rr_ptr unchanged.
//  Fairness: a continuously valid port is granted within NREQ accepts.
//  Overflow: the carry-out is discarded; no flag is produced.
//  Operands only need to be stable in the accepting cycle.
//  Reset mid-operation: a pending response is dropped (rsp_valid->0 immediately).
//   Requesters re-issue after reset.
//  Width rule: rr_ptr is ID_W bits; when NREQ is not a power of two, wrap explicitly.
// STRUCTURE
//  Package add_arb_pkg:
//   DATA_W=32
//   state enum {ST_EMPTY, ST_FULL}
//   function rr_next(ptr, n)
//  Sub-module rr_pick: combinational round-robin picker.
//   Inputs: req[NREQ], ptr. Outputs: gnt one-hot, gnt_idx, any.
//  Top level: rr_pick, operand mux, one Add instance, response register, FSM, counter.
// TESTING
//  1 Reset: hold rst_n=0 with req_valid=4'b1111.
//    -> req_ready=0, rsp_valid=0, grant_cnt=0.
//  2 Single add: port 2 requests a=32'h0000_FFFF, b=1; rsp_ready=1.
//    -> req_ready=4'b0100; next cycle rsp_sum=32'h0001_0000, rsp_id=2.
//  3 Round-robin: req_valid=4'b1111 for 8 cycles, rsp_ready=1.
//    -> ids 0,1,2,3,0,1,2,3; grant_cnt=8.
//  4 Backpressure: rsp_ready=0 with port 1 valid.
//    -> rsp_sum/rsp_id frozen, req_ready=0.
//    Raise rsp_ready -> port 1 granted in the same cycle.
//  5 Wrap: port 3 adds 32'hFFFF_FFFF + 1.
//    -> rsp_sum=0; then ports 0 and 3 valid -> port 0 granted first.
//  6 Mid-op reset: pulse rst_n low while FULL.
//    -> rsp_valid falls asynchronously; rr_ptr=0 afterwards.

Source files
------------

// File: rtl/add_arb_pkg.sv
// Shared definitions for the round-robin adder-sharing arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package add_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Pointer advance with an explicit wrap, so non-power-of-two port counts
  // never leave the pointer on an unused code.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/add_share_arbiter_add.sv
// Add: 32-bit adder built from 4-bit carry-lookahead groups chained by group carry.
// Latency: purely combinational.
// Backpressure: none; the carry-out of the top group is dropped (mod 2^32 result).
module Add
  import add_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] p;
  logic [3:0]        gb;
  logic [3:0]        pb;
  logic              cin;
  logic              c1;
  logic              c2;
  logic              c3;
  logic              c4;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    sum = '0;
    gb  = '0;
    pb  = '0;
    cin = 1'b0;
    c1  = 1'b0;
    c2  = 1'b0;
    c3  = 1'b0;
    c4  = 1'b0;
    for (int k = 0; k < DATA_W / 4; k++) begin
      gb = g[4*k +: 4];
      pb = p[4*k +: 4];
      // Every carry inside the group is a flat two-level term of the group input carry.
      c1 = gb[0] | (pb[0] & cin);
      c2 = gb[1] | (pb[1] & gb[0]) | (&pb[1:0] & cin);
      c3 = gb[2] | (pb[2] & gb[1]) | (&pb[2:1] & gb[0]) | (&pb[2:0] & cin);
      c4 = gb[3] | (pb[3] & gb[2]) | (&pb[3:2] & gb[1]) | (&pb[3:1] & gb[0])
         | (&pb[3:0] & cin);
      sum[4*k +: 4] = pb ^ {c3, c2, c1, cin};
      cin = c4;
    end
  end

endmodule

// File: rtl/add_share_arbiter_rr_pick.sv
// rr_pick: selects the first set request at or above ptr, wrapping NREQ-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; gating by the consumer is done by the caller.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: NREQ ports share one adder, granted round-robin; sum+id registered.
// Latency: 1 cycle from req_ready/req_valid acceptance to rsp_valid.
// Backpressure: a held response (rsp_ready=0) blocks all grants; throughput 1/cycle otherwise.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   per-port request handshake (ready is one-hot or zero)
//   req_a, req_b          per-port operands, port i at [32*i +: 32]
//   rsp_valid/rsp_ready   single response handshake; rsp_sum, rsp_id held while stalled
//   grant_cnt             accepted-request counter, wraps at 2^16
module add_share_arbiter
  import add_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_sum,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            grant_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              any;
  logic              can_accept;
  logic              grant;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] add_sum;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign op_a = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
  assign op_b = req_b[int'(gnt_idx)*DATA_W +: DATA_W];

  Add u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  // The response slot frees up in the same cycle the consumer takes it.
  assign can_accept = (state == ST_EMPTY) | rsp_ready;
  assign grant      = can_accept & any;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (grant) state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !grant) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Outputs. rst_n gates ready directly so no port sees an acceptance while reset is held.
  always_comb begin
    rsp_valid = (state == ST_FULL);
    req_ready = gnt & {NREQ{can_accept & rst_n}};
  end

  // Response register, pointer and counter advance only on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
      grant_cnt <= '0;
    end else if (grant) begin
      rsp_sum   <= add_sum;
      rsp_id    <= gnt_idx;
      rr_ptr    <= ID_W'(rr_next(int'(gnt_idx), NREQ));
      grant_cnt <= grant_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter: directed table, hand sequences and a randomized model check.
// Latency: n/a.
// Backpressure: n/a.
module tb_add_share_arbiter;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_sum;
  logic [1:0]        rsp_id;
  logic [15:0]       grant_cnt;

  int errors = 0;
  int checks = 0;

  add_share_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ready;
    logic [1:0]  id;
    logic [31:0] sum;
    int          cnt;   // -1: counter not checked on this row
  } vec_t;

  vec_t tbl [12];

  // Reference model state.
  logic [31:0] ma [NREQ];
  logic [31:0] mb [NREQ];
  int          m_ptr;
  bit          m_full;
  logic [31:0] m_sum;
  int          m_id;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Port p gets a_row + (p<<24) so a wrong operand mux shows up in the sum.
  task automatic set_ops(input logic [31:0] a_row, input logic [31:0] b_row);
    for (int p = 0; p < NREQ; p++) begin
      req_a[32*p +: 32] = a_row + (32'(p) << 24);
      req_b[32*p +: 32] = b_row;
    end
  endtask

  function automatic int pick(input logic [3:0] rv, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (rv[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  initial begin
    // Round-robin from reset, then single add, wrap, and resumed scan from pointer.
    tbl[0]  = '{4'b1111, 32'd0, 32'h100, 4'b0001, 2'd0, 32'h0000_0100, -1};
    tbl[1]  = '{4'b1111, 32'd1, 32'h100, 4'b0010, 2'd1, 32'h0100_0101, -1};
    tbl[2]  = '{4'b1111, 32'd2, 32'h100, 4'b0100, 2'd2, 32'h0200_0102, -1};
    tbl[3]  = '{4'b1111, 32'd3, 32'h100, 4'b1000, 2'd3, 32'h0300_0103, -1};
    tbl[4]  = '{4'b1111, 32'd4, 32'h100, 4'b0001, 2'd0, 32'h0000_0104, -1};
    tbl[5]  = '{4'b1111, 32'd5, 32'h100, 4'b0010, 2'd1, 32'h0100_0105, -1};
    tbl[6]  = '{4'b1111, 32'd6, 32'h100, 4'b0100, 2'd2, 32'h0200_0106, -1};
    tbl[7]  = '{4'b1111, 32'd7, 32'h100, 4'b1000, 2'd3, 32'h0300_0107, 8};
    tbl[8]  = '{4'b0100, 32'hFE00_FFFF, 32'd1, 4'b0100, 2'd2, 32'h0001_0000, 9};
    tbl[9]  = '{4'b1000, 32'hFCFF_FFFF, 32'd1, 4'b1000, 2'd3, 32'h0000_0000, 10};
    tbl[10] = '{4'b1001, 32'd5, 32'd6, 4'b0001, 2'd0, 32'h0000_000B, 11};
    tbl[11] = '{4'b1001, 32'd5, 32'd6, 4'b1000, 2'd3, 32'h0300_000B, 12};

    // Reset with every port requesting.
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    set_ops(32'd0, 32'd0);
    #12;
    chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_grant_cnt", {16'd0, grant_cnt}, 32'd0);
    chk("reset_rsp_sum", rsp_sum, 32'd0);
    chk("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 12; r++) begin
      req_valid = tbl[r].rv;
      rsp_ready = 1'b1;
      set_ops(tbl[r].a, tbl[r].b);
      #1;
      chk($sformatf("tbl%0d_ready", r), {28'd0, req_ready}, {28'd0, tbl[r].ready});
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", r), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("tbl%0d_id", r), {30'd0, rsp_id}, {30'd0, tbl[r].id});
      chk($sformatf("tbl%0d_sum", r), rsp_sum, tbl[r].sum);
      if (tbl[r].cnt >= 0) chk($sformatf("tbl%0d_cnt", r), {16'd0, grant_cnt}, 32'(tbl[r].cnt));
    end

    // Backpressure: held result, no grant, then grant in the cycle ready rises.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    set_ops(32'd7, 32'd8);
    #1;
    chk("bp_ready_low", {28'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_ops($urandom, $urandom);
      #1;
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_sum", rsp_sum, 32'h0300_000B);
      chk("bp_hold_id", {30'd0, rsp_id}, 32'd3);
      chk("bp_hold_ready", {28'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    set_ops(32'h10, 32'h20);
    #1;
    chk("bp_release_ready", {28'd0, req_ready}, 32'b0010);
    @(negedge clk);
    chk("bp_release_id", {30'd0, rsp_id}, 32'd1);
    chk("bp_release_sum", rsp_sum, 32'h0100_0030);
    chk("bp_release_cnt", {16'd0, grant_cnt}, 32'd13);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("drain_valid", {31'd0, rsp_valid}, 32'd0);

    // Mid-operation reset while a result is held.
    req_valid = 4'b0100;
    set_ops(32'd1, 32'd2);
    @(negedge clk);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    #2;
    chk("midrst_full", {31'd0, rsp_valid}, 32'd1);
    chk("midrst_full_id", {30'd0, rsp_id}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_ready", {28'd0, req_ready}, 32'd0);
    chk("midrst_cnt", {16'd0, grant_cnt}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    set_ops(32'd0, 32'd0);
    #1;
    chk("midrst_ptr0_ready", {28'd0, req_ready}, 32'b0001);
    @(negedge clk);
    chk("midrst_ptr0_id", {30'd0, rsp_id}, 32'd0);

    // Randomized run against the reference model, from a clean reset.
    req_valid = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_full = 1'b0;
    m_sum  = 32'd0;
    m_id   = 0;
    m_cnt  = 0;
    for (int c = 0; c < 400; c++) begin
      int g;
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NREQ; p++) begin
        ma[p] = $urandom;
        mb[p] = $urandom;
        req_a[32*p +: 32] = ma[p];
        req_b[32*p +: 32] = mb[p];
      end
      #1;
      chk("rnd_valid", {31'd0, rsp_valid}, {31'd0, m_full});
      if (m_full) begin
        chk("rnd_sum", rsp_sum, m_sum);
        chk("rnd_id", {30'd0, rsp_id}, 32'(m_id));
      end
      chk("rnd_cnt", {16'd0, grant_cnt}, 32'(m_cnt));
      g = (!m_full || rsp_ready) ? pick(req_valid, m_ptr) : -1;
      chk("rnd_ready", {28'd0, req_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
      if (!m_full || rsp_ready) begin
        if (g >= 0) begin
          m_full = 1'b1;
          m_sum  = ma[g] + mb[g];
          m_id   = g;
          m_ptr  = (g + 1) % NREQ;
          m_cnt  = (m_cnt + 1) % 65536;
        end else begin
          m_full = 1'b0;
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
